sd_host_regs: RTL and testbench
===============================

# sd_host_regs

Host-side register bank for the SD host controller: the responder to the req/wnr/address/data_in bus driven by the register-set stimulus and by the host interface. Decodes one access per clock with req high, holds control/argument/scratch registers, and exposes a sticky status register that the SD engine sets. Issues a command-start pulse to the command engine. Returns read data with a registered acknowledge.

## Interface
- NUM_REGS, 32, implemented register count; addresses >= NUM_REGS are unmapped
- VERSION, 8'h11, value returned by the read-only VERSION register
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  access request, sampled every rising edge; one access per cycle while high
- wnr  in  1  1 = write, 0 = read; qualified by req
- address  in  8  register address
- data_in  in  8  write data
- ack  out  1  access completed; high the cycle after each accepted req
- data_out  out  8  read data, valid while ack high
- err  out  1  access error, valid while ack high
- status_set  in  8  per-bit set strobes from SD engine into STATUS
- cmd_busy  in  1  command engine busy
- cmd_start  out  1  one-cycle pulse on accepted CMD write
- ctrl  out  8  CTRL register contents
- cmd  out  8  CMD register contents
- arg  out  32  ARG3..ARG0 concatenated, ARG3 most significant

## Operation
- Map: 0x00 CTRL RW; 0x01 STATUS W1C; 0x02 CMD RW; 0x03-0x06 ARG0-ARG3 RW; 0x07 VERSION RO; 0x08..NUM_REGS-1 SCRATCH RW; >= NUM_REGS unmapped.
- Read: data_out = register value sampled at the accepting edge; unmapped returns 8'h00 with err=1.
- Write RW: register updated at the accepting edge.
- Write STATUS: each data_in bit at 1 clears the matching STATUS bit; 0 bits unchanged.
- Write VERSION or unmapped: no state change, err=1.
- Write CMD while cmd_busy=1: CMD unchanged, no cmd_start, err=1.
- Write CMD while cmd_busy=0: CMD updated; cmd_start=1 the following cycle, for exactly one cycle.
- STATUS set: every cycle, STATUS |= status_set, independent of bus activity.
- Same-cycle set and W1C on one STATUS bit: set wins, bit ends at 1.
- Read of STATUS in the same cycle as status_set: returns the pre-update value; the new bit shows on the next read.
- req low: no access, ack=0 next cycle, data_out holds last value, err=0.

## Timing
- Latency: exactly 1 cycle req -> ack; fully pipelined, back-to-back accesses every cycle, no wait states.
- ack, err and cmd_start are registered; data_out registered.
- Read-after-write to the same address on consecutive cycles returns the newly written value.
- Reset (asynchronous, any time, including mid-stream): ack=0, err=0, cmd_start=0, data_out=8'h00, CTRL=CMD=ARG*=SCRATCH=STATUS=8'h00. Any access in flight is dropped; no ack is issued for it.
- First access is accepted on the first rising edge after reset deasserts.
- Address wrap (8'hFF -> 8'h00) needs no special handling; each address is decoded independently.

## Structure
- Shared package sd_host_pkg: register address constants (ADDR_CTRL, ADDR_STATUS, ADDR_CMD, ADDR_ARG0..ADDR_ARG3, ADDR_VERSION, ADDR_SCRATCH_BASE) and the default VERSION value. The command engine and benches reuse it.
- Single module; storage is an array of NUM_REGS bytes plus separate STATUS logic. No sub-module.

## Test plan
- Reset, then read 0x00..0x07 back-to-back with req held high -> ack every cycle from the second edge; data 00 except 0x07 = 8'h11; err=0.
- Write 8'hA5 to 0x10, read 0x10 on the next cycle -> data_out=8'hA5; write 0x07 -> err=1 and 0x07 still reads 8'h11.
- Sweep address 0x00..0xFF with req=wnr=1, data_in=5, as the existing stimulus does -> err=1 exactly for 0x07 and 0x20..0xFF; reads of 0x08..0x1F return 8'h05.
- status_set=8'h03 for one cycle, then write STATUS with 8'h01 -> STATUS reads 8'h02; pulsing status_set=8'h02 in the same cycle as a W1C of 8'h02 -> bit remains 1.
- Write CMD 8'h40 with cmd_busy=0 -> one-cycle cmd_start and cmd=8'h40; repeat with cmd_busy=1 and 8'h41 -> err=1, cmd_start stays 0, cmd stays 8'h40.
- Assert reset mid-sweep between edges -> ack/err/data_out go to 0 immediately; after release, all RW registers read 8'h00.

Source files
------------

// File: rtl/sd_host_pkg.sv
// Shared register map and constants for the SD host register bank.
// Reused by the command engine and by benches.
package sd_host_pkg;

  localparam logic [7:0] ADDR_CTRL         = 8'h00;
  localparam logic [7:0] ADDR_STATUS       = 8'h01;
  localparam logic [7:0] ADDR_CMD          = 8'h02;
  localparam logic [7:0] ADDR_ARG0         = 8'h03;
  localparam logic [7:0] ADDR_ARG1         = 8'h04;
  localparam logic [7:0] ADDR_ARG2         = 8'h05;
  localparam logic [7:0] ADDR_ARG3         = 8'h06;
  localparam logic [7:0] ADDR_VERSION      = 8'h07;
  localparam logic [7:0] ADDR_SCRATCH_BASE = 8'h08;

  localparam logic [7:0] VERSION_DEFAULT   = 8'h11;

endpackage

// File: rtl/sd_host_regs.sv
// Host-side register bank: one access per clock, registered ack/err/data_out,
// sticky STATUS set by the SD engine and cleared by write-one-to-clear,
// and a one-cycle cmd_start pulse on an accepted CMD write.
module sd_host_regs
  import sd_host_pkg::*;
#(
  parameter int         NUM_REGS = 32,
  parameter logic [7:0] VERSION  = VERSION_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wnr,
  input  logic [7:0]  address,
  input  logic [7:0]  data_in,
  output logic        ack,
  output logic [7:0]  data_out,
  output logic        err,
  input  logic [7:0]  status_set,
  input  logic        cmd_busy,
  output logic        cmd_start,
  output logic [7:0]  ctrl,
  output logic [7:0]  cmd,
  output logic [31:0] arg
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Slots for STATUS and VERSION exist in the array but are never written;
  // those addresses are served by dedicated logic.
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic [7:0] status_q, status_d;
  logic [7:0] data_out_q, data_out_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       cmd_start_q, cmd_start_d;
  logic [7:0] w1c_mask;

  logic             mapped;
  logic [IDX_W-1:0] idx;

  assign mapped = ({24'd0, address} < 32'(NUM_REGS));
  assign idx    = address[IDX_W-1:0];

  // Access decode, next-state for register array, STATUS and bus response.
  always_comb begin
    regs_d      = regs_q;
    w1c_mask    = 8'h00;
    ack_d       = req;
    err_d       = 1'b0;
    cmd_start_d = 1'b0;
    data_out_d  = data_out_q;
    if (req) begin
      if (!wnr) begin
        data_out_d = 8'h00;
        err_d      = !mapped;
        if (mapped) begin
          case (address)
            ADDR_STATUS:  data_out_d = status_q;
            ADDR_VERSION: data_out_d = VERSION;
            default:      data_out_d = regs_q[idx];
          endcase
        end
      end else if (!mapped || address == ADDR_VERSION) begin
        err_d = 1'b1;
      end else if (address == ADDR_STATUS) begin
        w1c_mask = data_in;
      end else if (address == ADDR_CMD) begin
        if (cmd_busy) begin
          err_d = 1'b1;
        end else begin
          regs_d[idx] = data_in;
          cmd_start_d = 1'b1;
        end
      end else begin
        regs_d[idx] = data_in;
      end
    end
    // Set strobes are applied after the clear so a same-cycle set wins.
    status_d = (status_q & ~w1c_mask) | status_set;
  end

  // State and registered outputs; reset drops any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      status_q    <= 8'h00;
      data_out_q  <= 8'h00;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      cmd_start_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      status_q    <= status_d;
      data_out_q  <= data_out_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      cmd_start_q <= cmd_start_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign data_out  = data_out_q;
  assign cmd_start = cmd_start_q;
  assign ctrl      = regs_q[0];
  assign cmd       = regs_q[2];
  assign arg       = {regs_q[6], regs_q[5], regs_q[4], regs_q[3]};

endmodule

// File: tb/tb_sd_host_regs.sv
// Directed bench for sd_host_regs: vector table plus hand sequences for the
// address sweep and mid-stream reset.
module tb_sd_host_regs;
  import sd_host_pkg::*;

  logic        clk, reset, req, wnr, cmd_busy;
  logic [7:0]  address, data_in, status_set;
  logic        ack, err, cmd_start;
  logic [7:0]  data_out, ctrl, cmd;
  logic [31:0] arg;

  int n_cmp = 0;
  int n_bad = 0;

  sd_host_regs dut (
    .clk(clk), .reset(reset), .req(req), .wnr(wnr), .address(address),
    .data_in(data_in), .ack(ack), .data_out(data_out), .err(err),
    .status_set(status_set), .cmd_busy(cmd_busy), .cmd_start(cmd_start),
    .ctrl(ctrl), .cmd(cmd), .arg(arg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req, wnr;
    logic [7:0] addr, din, sset;
    logic       busy;
    logic       e_ack, e_err, e_start, c_dout;
    logic [7:0] e_dout;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic w, logic [7:0] a, logic [7:0] d,
                              logic [7:0] s, logic b, logic ea, logic ee,
                              logic es, logic cd, logic [7:0] ed);
    vec_t v;
    v.req = r; v.wnr = w; v.addr = a; v.din = d; v.sset = s; v.busy = b;
    v.e_ack = ea; v.e_err = ee; v.e_start = es; v.c_dout = cd; v.e_dout = ed;
    return v;
  endfunction

  function automatic vec_t rd(logic [7:0] a, logic [7:0] ed, logic ee);
    return mk(1, 0, a, 8'h00, 8'h00, 0, 1, ee, 0, 1, ed);
  endfunction

  function automatic vec_t wr(logic [7:0] a, logic [7:0] d, logic ee, logic es);
    return mk(1, 1, a, d, 8'h00, 0, 1, ee, es, 0, 8'h00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] s, input logic b);
    req = r; wnr = w; address = a; data_in = d; status_set = s; cmd_busy = b;
  endtask

  task automatic apply(input vec_t v, input int i);
    drive(v.req, v.wnr, v.addr, v.din, v.sset, v.busy);
    @(posedge clk); #1;
    check($sformatf("v%0d ack", i), {31'd0, ack}, {31'd0, v.e_ack});
    check($sformatf("v%0d err", i), {31'd0, err}, {31'd0, v.e_err});
    check($sformatf("v%0d cmd_start", i), {31'd0, cmd_start}, {31'd0, v.e_start});
    if (v.c_dout) check($sformatf("v%0d data_out", i), {24'd0, data_out}, {24'd0, v.e_dout});
  endtask

  initial begin
    drive(0, 0, 8'h00, 8'h00, 8'h00, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst ack", {31'd0, ack}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst data_out", {24'd0, data_out}, 32'd0);
    check("rst ctrl_cmd_arg", {16'd0, ctrl, cmd} | arg, 32'd0);

    // Back-to-back reads of the fixed map right after reset.
    for (int a = 0; a < 8; a++) vq.push_back(rd(8'(a), (a == 7) ? 8'h11 : 8'h00, 0));
    // Scratch write then read-after-write; VERSION write is rejected.
    vq.push_back(wr(8'h10, 8'hA5, 0, 0));
    vq.push_back(rd(8'h10, 8'hA5, 0));
    vq.push_back(wr(ADDR_VERSION, 8'h55, 1, 0));
    vq.push_back(rd(ADDR_VERSION, 8'h11, 0));
    // Idle cycle holds data_out, clears err, and sets STATUS bits 1:0.
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 8'h03, 0, 0, 0, 0, 1, 8'h11));
    vq.push_back(rd(ADDR_STATUS, 8'h03, 0));
    vq.push_back(wr(ADDR_STATUS, 8'h01, 0, 0));
    vq.push_back(rd(ADDR_STATUS, 8'h02, 0));
    // Read concurrent with a set returns the old value.
    vq.push_back(mk(1, 0, ADDR_STATUS, 8'h00, 8'h04, 0, 1, 0, 0, 1, 8'h02));
    vq.push_back(rd(ADDR_STATUS, 8'h06, 0));
    // Set and W1C on the same bit: set wins.
    vq.push_back(mk(1, 1, ADDR_STATUS, 8'h02, 8'h02, 0, 1, 0, 0, 0, 8'h00));
    vq.push_back(rd(ADDR_STATUS, 8'h06, 0));
    vq.push_back(wr(ADDR_STATUS, 8'hFF, 0, 0));
    vq.push_back(rd(ADDR_STATUS, 8'h00, 0));
    // Unmapped accesses.
    vq.push_back(rd(8'h20, 8'h00, 1));
    vq.push_back(rd(8'hFF, 8'h00, 1));
    vq.push_back(wr(8'h80, 8'h77, 1, 0));
    // CTRL and ARG bytes.
    vq.push_back(wr(ADDR_CTRL, 8'h5A, 0, 0));
    vq.push_back(wr(ADDR_ARG0, 8'h11, 0, 0));
    vq.push_back(wr(ADDR_ARG1, 8'h22, 0, 0));
    vq.push_back(wr(ADDR_ARG2, 8'h33, 0, 0));
    vq.push_back(wr(ADDR_ARG3, 8'h44, 0, 0));
    vq.push_back(rd(ADDR_ARG2, 8'h33, 0));
    // CMD accepted when idle, rejected when busy.
    vq.push_back(wr(ADDR_CMD, 8'h40, 0, 1));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h33));
    vq.push_back(mk(1, 1, ADDR_CMD, 8'h41, 8'h00, 1, 1, 1, 0, 0, 8'h00));
    vq.push_back(rd(ADDR_CMD, 8'h40, 0));

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    check("ctrl out", {24'd0, ctrl}, 32'h0000_005A);
    check("cmd out", {24'd0, cmd}, 32'h0000_0040);
    check("arg out", arg, 32'h4433_2211);

    // Full write sweep with data 5, req held high.
    for (int a = 0; a < 256; a++) begin
      drive(1, 1, 8'(a), 8'h05, 8'h00, 0);
      @(posedge clk); #1;
      check($sformatf("sweep %0d ack", a), {31'd0, ack}, 32'd1);
      check($sformatf("sweep %0d err", a), {31'd0, err}, {31'd0, (a == 7 || a >= 32)});
      check($sformatf("sweep %0d cmd_start", a), {31'd0, cmd_start}, {31'd0, (a == 2)});
    end
    for (int a = 8; a < 32; a++) begin
      drive(1, 0, 8'(a), 8'h00, 8'h00, 0);
      @(posedge clk); #1;
      check($sformatf("scratch rd %0d", a), {23'd0, err, data_out}, 32'h0000_0005);
    end
    check("sweep arg", arg, 32'h0505_0505);
    check("sweep ctrl/cmd", {16'd0, ctrl, cmd}, 32'h0000_0505);

    // Mid-stream reset between edges while writes are in flight.
    for (int a = 16; a < 20; a++) begin
      drive(1, 1, 8'(a), 8'hC3, 8'h00, 0);
      @(posedge clk); #1;
    end
    drive(1, 1, ADDR_CMD, 8'h99, 8'h00, 0);
    @(posedge clk); #1;
    check("pre-rst cmd_start", {31'd0, cmd_start}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid-rst ack", {31'd0, ack}, 32'd0);
    check("mid-rst err", {31'd0, err}, 32'd0);
    check("mid-rst data_out", {24'd0, data_out}, 32'd0);
    check("mid-rst cmd_start", {31'd0, cmd_start}, 32'd0);
    @(posedge clk); #1;
    check("held-rst ack", {31'd0, ack}, 32'd0);
    drive(1, 0, ADDR_CTRL, 8'h00, 8'h00, 0);
    #3 reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      drive(1, 0, 8'(a), 8'h00, 8'h00, 0);
      @(posedge clk); #1;
      check($sformatf("post-rst rd %0d", a), {22'd0, ack, err, data_out},
            {22'd0, 1'b1, 1'b0, (a == 7) ? 8'h11 : 8'h00});
    end
    drive(0, 0, 8'h00, 8'h00, 8'h00, 0);
    @(posedge clk); #1;
    check("final idle ack", {31'd0, ack}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
